// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 device-to-host transmitter.
//   ps2_state_e    - transmitter FSM states
//   PS2_START/STOP - framing bit values
//   PS2_FRAME_BITS - bits per frame (start + 8 data + parity + stop)
//   odd_parity()   - parity bit that makes the 9-bit data+parity group odd
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_CLK_LO = 2'd2,
    ST_GAP    = 2'd3
  } ps2_state_e;

  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;
  localparam int   PS2_FRAME_BITS = 11;
  localparam logic [3:0] PS2_LAST_IDX = 4'(PS2_FRAME_BITS - 1);

  // 1 when the byte has an even number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: two-flop synchronizer for the asynchronous PS/2 clock line.
//   clk      - system clock
//   rst_n    - asynchronous active-low reset (flops reset to 1 = line idle)
//   async_in - raw wire value
//   sync_out - value safe to use in the clk domain (2-cycle latency)
module ps2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/ps2_dev_tx.sv
// ps2_dev_tx: PS/2 device-side byte transmitter (device generates the clock).
//   clk, rst_n          - system clock, asynchronous active-low reset
//   tx_data, tx_valid   - byte to send and request; accepted when tx_ready=1
//   tx_ready            - idle, warmed up and host not inhibiting the clock
//   tx_done, tx_abort   - one-cycle completion / host-abort pulses
//   ps2_clk_o, ps2_data_o - line drives: 0 = pull low, 1 = release
//   ps2_clk_i           - PS/2 clock wire as seen externally (asynchronous)
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 2160,
  parameter int GAP_CYCLES      = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       ps2_clk_o,
  output logic       ps2_data_o,
  input  logic       ps2_clk_i
);

  localparam int CNT_MAX = (HALF_BIT_CYCLES > GAP_CYCLES) ? HALF_BIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  // Our own CLK_LO is still visible through the synchronizer for the first
  // cycles of DRIVE; only a low seen after this point belongs to the host.
  localparam logic [CNT_W-1:0] ABORT_MIN = CNT_W'(4);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  ps2_state_e                state_reg, state_next;
  logic [3:0]                idx_reg, idx_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [PS2_FRAME_BITS-1:0] frame_reg, frame_next;
  logic                      done_reg, done_next;
  logic                      abort_reg, abort_next;
  logic                      clk_o_reg, clk_o_next;
  logic                      data_o_reg, data_o_next;
  logic [1:0]                warm_reg;
  logic                      clk_sync;

  ps2_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ps2_clk_i),
    .sync_out (clk_sync)
  );

  // The synchronizer resets to 1, so hold tx_ready off until it has been
  // refilled from the real wire.
  assign tx_ready   = (state_reg == ST_IDLE) && clk_sync && warm_reg[1];
  assign tx_done    = done_reg;
  assign tx_abort   = abort_reg;
  assign ps2_clk_o  = clk_o_reg;
  assign ps2_data_o = data_o_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    frame_next = frame_reg;
    done_next  = 1'b0;
    abort_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          frame_next = {PS2_STOP, odd_parity(tx_data), tx_data, PS2_START};
          state_next = ST_DRIVE;
          idx_next   = 4'd0;
          cnt_next   = '0;
        end
      end
      ST_DRIVE: begin
        if ((idx_reg != PS2_LAST_IDX) && (cnt_reg >= ABORT_MIN) && !clk_sync) begin
          state_next = ST_GAP;
          idx_next   = 4'd0;
          cnt_next   = '0;
          abort_next = 1'b1;
        end else if (cnt_reg == HALF_LAST) begin
          state_next = ST_CLK_LO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_CLK_LO: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (idx_reg == PS2_LAST_IDX) begin
            state_next = ST_GAP;
            idx_next   = 4'd0;
            done_next  = 1'b1;
          end else begin
            state_next = ST_DRIVE;
            idx_next   = idx_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Line drives are registered from the next state so the pins never
    // glitch; data only moves on DRIVE entry because frame/idx are constant
    // across a DRIVE+CLK_LO pair.
    clk_o_next  = (state_next != ST_CLK_LO);
    data_o_next = 1'b1;
    if ((state_next == ST_DRIVE) || (state_next == ST_CLK_LO)) begin
      data_o_next = frame_next[idx_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= 4'd0;
      cnt_reg    <= '0;
      frame_reg  <= '1;
      done_reg   <= 1'b0;
      abort_reg  <= 1'b0;
      clk_o_reg  <= 1'b1;
      data_o_reg <= 1'b1;
      warm_reg   <= 2'b00;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      frame_reg  <= frame_next;
      done_reg   <= done_next;
      abort_reg  <= abort_next;
      clk_o_reg  <= clk_o_next;
      data_o_reg <= data_o_next;
      warm_reg   <= {warm_reg[0], 1'b1};
    end
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb_ps2_dev_tx: self-checking bench for ps2_dev_tx with scaled timing.
// Expected frames come from the framing rules (start, LSB-first data,
// odd parity, stop); expected timing from 22 half-bits plus the gap.
module tb_ps2_dev_tx;

  localparam int H           = 8;
  localparam int G           = 16;
  localparam int ACC_TO_DONE = 22 * H;
  localparam int ACC_TO_IDLE = 22 * H + G;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_abort, ps2_clk_o, ps2_data_o;
  logic       host_clk = 1'b1;
  logic       ps2_clk_i;

  // Open-collector wire: low if either side pulls it low.
  assign ps2_clk_i = ps2_clk_o & host_clk;

  always #5 clk = ~clk;

  ps2_dev_tx #(.HALF_BIT_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort),
    .ps2_clk_o  (ps2_clk_o),
    .ps2_data_o (ps2_data_o),
    .ps2_clk_i  (ps2_clk_i)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bad_changes = 0;
  int   acc_q[$];
  int   done_q[$];
  int   abort_q[$];
  int   ready_q[$];
  logic fall_q[$];
  logic last_clk_o = 1'b1;
  logic last_data = 1'b1;
  logic last_ready = 1'b0;

  // Acceptance is decided by values present just before the rising edge.
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) acc_q.push_back(cyc + 1);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (tx_done) done_q.push_back(cyc);
    if (tx_abort) abort_q.push_back(cyc);
    if (tx_ready && !last_ready) ready_q.push_back(cyc);
    if (last_clk_o && !ps2_clk_o) fall_q.push_back(ps2_data_o);
    if (!ps2_clk_o && (ps2_data_o !== last_data)) bad_changes <= bad_changes + 1;
    last_clk_o <= ps2_clk_o;
    last_data  <= ps2_data_o;
    last_ready <= tx_ready;
  end

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (i == 9) return (($countones(d) % 2) == 0);
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    acc_q.delete();
    done_q.delete();
    abort_q.delete();
    ready_q.delete();
    fall_q.delete();
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    int n = 0;
    while (!tx_ready && n < budget) begin
      tick();
      n++;
    end
    ok = tx_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({ps2_clk_o, ps2_data_o, tx_ready, tx_done, tx_abort} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 11000",
               {ps2_clk_o, ps2_data_o, tx_ready, tx_done, tx_abort});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early: got %b expected 0", tx_ready);
    end
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b expected 1", tx_ready);
    end
  endtask

  task automatic test_frame(input logic [7:0] d);
    bit ok;
    wait_ready(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_ready_pre: got 0 expected 1");
    end
    clear_q();
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    wait_ready(ACC_TO_IDLE + 20, ok);
    checks++;
    if (!ok || acc_q.size() != 1 || done_q.size() != 1 || ready_q.size() < 1) begin
      errors++;
      $display("FAIL frame_events: got acc=%0d done=%0d ready=%0d expected 1 1 1",
               acc_q.size(), done_q.size(), ready_q.size());
    end else begin
      $display("frame 0x%02h accepted at %0d done at %0d ready at %0d",
               d, acc_q[0], done_q[0], ready_q[0]);
      checks++;
      if (done_q[0] - acc_q[0] != ACC_TO_DONE) begin
        errors++;
        $display("FAIL frame_done_time: got %0d expected %0d", done_q[0] - acc_q[0], ACC_TO_DONE);
      end
      checks++;
      if (ready_q[0] - acc_q[0] != ACC_TO_IDLE) begin
        errors++;
        $display("FAIL frame_ready_time: got %0d expected %0d", ready_q[0] - acc_q[0], ACC_TO_IDLE);
      end
    end
    checks++;
    if (fall_q.size() != 11) begin
      errors++;
      $display("FAIL frame_bit_count: got %0d expected 11", fall_q.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (fall_q[i] !== exp_bit(d, i)) begin
          errors++;
          $display("FAIL frame_bit[%0d] data 0x%02h: got %b expected %b", i, d, fall_q[i], exp_bit(d, i));
        end
      end
    end
    checks++;
    if (abort_q.size() != 0 || bad_changes != 0) begin
      errors++;
      $display("FAIL frame_clean: got aborts=%0d bad_changes=%0d expected 0 0", abort_q.size(), bad_changes);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    wait_ready(50, ok);
    clear_q();
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 20) begin tick(); n++; end
    tx_data = 8'h00;
    n = 0;
    while (acc_q.size() < 2 && n < ACC_TO_IDLE + 20) begin tick(); n++; end
    tx_valid = 1'b0;
    n = 0;
    while ((done_q.size() < 2 || !tx_ready) && n < ACC_TO_IDLE + 20) begin tick(); n++; end
    checks++;
    if (acc_q.size() != 2 || done_q.size() != 2 || fall_q.size() != 22) begin
      errors++;
      $display("FAIL b2b_events: got acc=%0d done=%0d bits=%0d expected 2 2 22",
               acc_q.size(), done_q.size(), fall_q.size());
    end else begin
      $display("b2b frames 0xFF at %0d and 0x00 at %0d", acc_q[0], acc_q[1]);
      // Second frame is accepted on the one IDLE cycle that follows the gap.
      checks++;
      if (acc_q[1] - acc_q[0] != ACC_TO_IDLE + 1) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d expected %0d", acc_q[1] - acc_q[0], ACC_TO_IDLE + 1);
      end
      checks++;
      if (fall_q[9] !== 1'b1 || fall_q[20] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_parity: got %b%b expected 11", fall_q[9], fall_q[20]);
      end
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (fall_q[i] !== exp_bit(8'hFF, i) || fall_q[11+i] !== exp_bit(8'h00, i)) begin
          errors++;
          $display("FAIL b2b_bit[%0d]: got %b%b expected %b%b", i, fall_q[i], fall_q[11+i],
                   exp_bit(8'hFF, i), exp_bit(8'h00, i));
        end
      end
    end
  endtask

  task automatic test_inhibit();
    bit ok;
    int n;
    int ready_seen = 0;
    int rel;
    wait_ready(50, ok);
    clear_q();
    host_clk = 1'b0;
    tick(); tick(); tick();
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_ready) ready_seen++;
    end
    checks++;
    if (ready_seen != 0 || acc_q.size() != 0 || ps2_clk_o !== 1'b1 || ps2_data_o !== 1'b1) begin
      errors++;
      $display("FAIL inhibit_hold: got ready=%0d acc=%0d clk=%b data=%b expected 0 0 1 1",
               ready_seen, acc_q.size(), ps2_clk_o, ps2_data_o);
    end
    rel = cyc;
    host_clk = 1'b1;
    n = 0;
    while (acc_q.size() < 1 && n < 10) begin tick(); n++; end
    tx_valid = 1'b0;
    checks++;
    if (acc_q.size() != 1 || acc_q[0] - rel < 2 || acc_q[0] - rel > 3) begin
      errors++;
      $display("FAIL inhibit_release: got acc=%0d delay=%0d expected 1 and 2..3",
               acc_q.size(), (acc_q.size() > 0) ? acc_q[0] - rel : -1);
    end else begin
      $display("inhibit released at %0d accepted at %0d", rel, acc_q[0]);
    end
    wait_ready(ACC_TO_IDLE + 20, ok);
    checks++;
    if (!ok || fall_q.size() != 11 || done_q.size() != 1) begin
      errors++;
      $display("FAIL inhibit_frame: got bits=%0d done=%0d expected 11 1", fall_q.size(), done_q.size());
    end
  endtask

  task automatic test_abort();
    bit ok;
    int n;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    wait_ready(50, ok);
    clear_q();
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!(fall_q.size() == 5 && ps2_clk_o) && n < ACC_TO_IDLE) begin tick(); n++; end
    host_clk = 1'b0;
    n = 0;
    while (abort_q.size() < 1 && n < 2 * H) begin tick(); n++; end
    checks++;
    if (abort_q.size() != 1 || ps2_clk_o !== 1'b1 || ps2_data_o !== 1'b1) begin
      errors++;
      $display("FAIL abort_pulse: got aborts=%0d clk=%b data=%b expected 1 1 1",
               abort_q.size(), ps2_clk_o, ps2_data_o);
    end
    tick(); tick(); tick();
    host_clk = 1'b1;
    wait_ready(G + 20, ok);
    checks++;
    if (!ok || abort_q.size() != 1 || done_q.size() != 0 || fall_q.size() != 5) begin
      errors++;
      $display("FAIL abort_after: got aborts=%0d done=%0d bits=%0d expected 1 0 5",
               abort_q.size(), done_q.size(), fall_q.size());
    end else begin
      $display("abort of 0x%02h at %0d ready at %0d", d, abort_q[0], cyc);
      checks++;
      if (ready_q.size() != 1 || ready_q[0] - abort_q[0] != G) begin
        errors++;
        $display("FAIL abort_gap: got %0d expected %0d",
                 (ready_q.size() > 0) ? ready_q[0] - abort_q[0] : -1, G);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int n;
    wait_ready(50, ok);
    clear_q();
    tx_data  = 8'h1C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (!(fall_q.size() == 4 && !ps2_clk_o) && n < ACC_TO_IDLE) begin tick(); n++; end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_o, ps2_data_o, tx_ready, tx_done, tx_abort} !== 5'b11000) begin
      errors++;
      $display("FAIL midreset_outputs: got %b expected 11000",
               {ps2_clk_o, ps2_data_o, tx_ready, tx_done, tx_abort});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready_early: got %b expected 0", tx_ready);
    end
    tick();
    checks++;
    if (tx_ready !== 1'b1 || done_q.size() != 0 || abort_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_after: got ready=%b done=%0d abort=%0d expected 1 0 0",
               tx_ready, done_q.size(), abort_q.size());
    end
    $display("mid-frame reset released, resending 0x1C");
    test_frame(8'h1C);
  endtask

  initial begin
    test_reset();
    test_frame(8'h1C);
    for (int k = 0; k < 4; k++) test_frame(8'($urandom_range(0, 255)));
    test_back_to_back();
    test_inhibit();
    test_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
